// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory port arbiter.
// Optional feature macro used by this slice: MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_WAIT = 2'd1,
    DATA_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle watchdog for the memory port arbiter.
// Instantiated only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // count wait cycles already spent; expired flags the last allowed one
  always_ff @(posedge Clock) begin
    if (Reset || clear)
      count <= '0;
    else if (enable && !expired)
      count <= count + 1'b1;
  end

  assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port.
// Optional wait watchdog: define MEM_ARB_TIMEOUT_EN.
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Fetch_Req,
  input  logic [ADDR_W-1:0] Fetch_Addr,
  output logic              Fetch_Done,
  output logic [DATA_W-1:0] Fetch_Data,
  input  logic              Data_Req,
  input  logic              Data_Write,
  input  logic [ADDR_W-1:0] Data_Addr,
  input  logic [DATA_W-1:0] Data_WData,
  output logic              Data_Done,
  output logic [DATA_W-1:0] Data_RData,
  output logic              Mem_Req,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  input  logic              Mem_Ready,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic              Stall,
  output logic              Timeout_Error
`else
  output logic              Stall
`endif
);

  state_t state;
  grant_t last_grant;

  logic fetch_elig;
  logic data_elig;
  logic pick_data;
  logic in_wait;
  logic timeout_hit;
  logic finish;

  // a requester completing this cycle may not be re-granted
  assign fetch_elig = Fetch_Req & ~Fetch_Done;
  assign data_elig  = Data_Req & ~Data_Done;

  // data first, unless data just finished and fetch is waiting
  assign pick_data = data_elig &
                     ~(fetch_elig & (last_grant == GRANT_DATA));

  assign in_wait = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .Clock   (Clock),
    .Reset   (Reset),
    .enable  (in_wait & ~Mem_Ready),
    .clear   (~in_wait),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign finish = in_wait & (Mem_Ready | timeout_hit);

  // combinational stall toward the pipeline
  assign Stall = (Fetch_Req & ~Fetch_Done) |
                 (Data_Req & ~Data_Done);

  // grant, hold memory fields during wait, complete on ready
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      last_grant <= GRANT_FETCH;
      Mem_Req    <= 1'b0;
      Mem_Write  <= 1'b0;
      Mem_Addr   <= '0;
      Mem_WData  <= '0;
      Fetch_Done <= 1'b0;
      Fetch_Data <= '0;
      Data_Done  <= 1'b0;
      Data_RData <= '0;
    end else begin
      Fetch_Done <= 1'b0;
      Data_Done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_data) begin
            Mem_Req   <= 1'b1;
            Mem_Write <= Data_Write;
            Mem_Addr  <= Data_Addr;
            Mem_WData <= Data_WData;
            state     <= DATA_WAIT;
          end else if (fetch_elig) begin
            Mem_Req   <= 1'b1;
            Mem_Write <= 1'b0;
            Mem_Addr  <= Fetch_Addr;
            Mem_WData <= '0;
            state     <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (finish) begin
            Fetch_Done <= 1'b1;
            Fetch_Data <= Mem_Ready ? Mem_RData : '0;
            Mem_Req    <= 1'b0;
            last_grant <= GRANT_FETCH;
            state      <= IDLE;
          end
        end
        DATA_WAIT: begin
          if (finish) begin
            Data_Done  <= 1'b1;
            Data_RData <= (Mem_Ready & ~Mem_Write) ?
                          Mem_RData : '0;
            Mem_Req    <= 1'b0;
            last_grant <= GRANT_DATA;
            state      <= IDLE;
          end
        end
        default: begin
          Mem_Req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // sticky timeout flag, cleared only by reset
  always_ff @(posedge Clock) begin
    if (Reset)
      Timeout_Error <= 1'b0;
    else if (timeout_hit)
      Timeout_Error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter.
// Covers the MEM_ARB_TIMEOUT_EN build when that macro is defined.
module tb_memory_port_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Fetch_Req;
  logic [31:0] Fetch_Addr;
  logic        Fetch_Done;
  logic [31:0] Fetch_Data;
  logic        Data_Req;
  logic        Data_Write;
  logic [31:0] Data_Addr;
  logic [31:0] Data_WData;
  logic        Data_Done;
  logic [31:0] Data_RData;
  logic        Mem_Req;
  logic        Mem_Write;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic [31:0] Mem_RData;
  logic        Mem_Ready;
  logic        Stall;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        Timeout_Error;
`endif

  int total = 0;
  int bad   = 0;

  memory_port_arbiter dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Fetch_Req  (Fetch_Req),
    .Fetch_Addr (Fetch_Addr),
    .Fetch_Done (Fetch_Done),
    .Fetch_Data (Fetch_Data),
    .Data_Req   (Data_Req),
    .Data_Write (Data_Write),
    .Data_Addr  (Data_Addr),
    .Data_WData (Data_WData),
    .Data_Done  (Data_Done),
    .Data_RData (Data_RData),
    .Mem_Req    (Mem_Req),
    .Mem_Write  (Mem_Write),
    .Mem_Addr   (Mem_Addr),
    .Mem_WData  (Mem_WData),
    .Mem_RData  (Mem_RData),
    .Mem_Ready  (Mem_Ready),
`ifdef MEM_ARB_TIMEOUT_EN
    .Stall         (Stall),
    .Timeout_Error (Timeout_Error)
`else
    .Stall      (Stall)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mreq"}, {31'd0, Mem_Req}, 0);
    check({tag, "_mwr"}, {31'd0, Mem_Write}, 0);
    check({tag, "_maddr"}, Mem_Addr, 0);
    check({tag, "_mwdata"}, Mem_WData, 0);
    check({tag, "_fdone"}, {31'd0, Fetch_Done}, 0);
    check({tag, "_ddone"}, {31'd0, Data_Done}, 0);
    check({tag, "_fdata"}, Fetch_Data, 0);
    check({tag, "_rdata"}, Data_RData, 0);
  endtask

  // reference-model state for the random section
  bit          last_was_data;
  bit          want_f, want_d, pend_f, pend_d;
  bit          first_is_data, cur_is_data, seen_req;
  bit          served_f, served_d;
  logic [31:0] fa, da, dwd, rd, exp_f, exp_d;
  bit          dw;
  int          delay, wait_cnt;

  initial begin
    Reset = 1'b1;
    Fetch_Req = 0; Fetch_Addr = 0;
    Data_Req = 0; Data_Write = 0;
    Data_Addr = 0; Data_WData = 0;
    Mem_RData = 0; Mem_Ready = 0;
    step();
    step();
    check_reset_outputs("reset");
    check("reset_stall", {31'd0, Stall}, 0);
    Reset = 1'b0;
    step();

    // ready while idle must be ignored
    Mem_Ready = 1'b1;
    Mem_RData = 32'hCAFE0000;
    step();
    check("idle_rdy_mreq", {31'd0, Mem_Req}, 0);
    check("idle_rdy_fdone", {31'd0, Fetch_Done}, 0);
    check("idle_rdy_ddone", {31'd0, Data_Done}, 0);
    Mem_Ready = 1'b0;
    step();

    // single fetch, minimum latency
    Fetch_Req = 1'b1;
    Fetch_Addr = 32'h40;
    #1;
    check("f1_stall_c0", {31'd0, Stall}, 1);
    step();
    check("f1_mreq_c1", {31'd0, Mem_Req}, 1);
    check("f1_maddr_c1", Mem_Addr, 32'h40);
    check("f1_mwr_c1", {31'd0, Mem_Write}, 0);
    Mem_Ready = 1'b1;
    Mem_RData = 32'h12345678;
    step();
    check("f1_done_c2", {31'd0, Fetch_Done}, 1);
    check("f1_data_c2", Fetch_Data, 32'h12345678);
    check("f1_mreq_c2", {31'd0, Mem_Req}, 0);
    check("f1_stall_c2", {31'd0, Stall}, 0);
    Fetch_Req = 1'b0;
    Mem_Ready = 1'b0;
    step();
    check("f1_done_c3", {31'd0, Fetch_Done}, 0);

    // simultaneous requests: data then fetch
    Fetch_Req = 1'b1; Fetch_Addr = 32'h80;
    Data_Req = 1'b1; Data_Write = 1'b0; Data_Addr = 32'h200;
    step();
    check("both_maddr_c1", Mem_Addr, 32'h200);
    Mem_Ready = 1'b1; Mem_RData = 32'hAAAA0001;
    step();
    check("both_ddone_c2", {31'd0, Data_Done}, 1);
    check("both_rdata_c2", Data_RData, 32'hAAAA0001);
    check("both_stall_c2", {31'd0, Stall}, 1);
    Data_Req = 1'b0; Mem_Ready = 1'b0;
    step();
    check("both_mreq_c3", {31'd0, Mem_Req}, 1);
    check("both_maddr_c3", Mem_Addr, 32'h80);
    check("both_stall_c3", {31'd0, Stall}, 1);
    Mem_Ready = 1'b1; Mem_RData = 32'hBBBB0002;
    step();
    check("both_fdone_c4", {31'd0, Fetch_Done}, 1);
    check("both_fdata_c4", Fetch_Data, 32'hBBBB0002);
    check("both_stall_c4", {31'd0, Stall}, 0);
    Fetch_Req = 1'b0; Mem_Ready = 1'b0;
    step();

    // store with three cycles of wait
    Data_Req = 1'b1; Data_Write = 1'b1;
    Data_Addr = 32'h100; Data_WData = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("st_mreq", {31'd0, Mem_Req}, 1);
      check("st_mwr", {31'd0, Mem_Write}, 1);
      check("st_maddr", Mem_Addr, 32'h100);
      check("st_mwdata", Mem_WData, 32'hDEADBEEF);
      check("st_ddone_wait", {31'd0, Data_Done}, 0);
      Mem_Ready = (c == 4);
      Mem_RData = 32'hFFFFFFFF;
    end
    step();
    check("st_ddone", {31'd0, Data_Done}, 1);
    check("st_rdata_zero", Data_RData, 0);
    Data_Req = 1'b0; Mem_Ready = 1'b0;
    step();
    check("st_ddone_once", {31'd0, Data_Done}, 0);

    // reset in the middle of a data wait
    Data_Req = 1'b1; Data_Write = 1'b0; Data_Addr = 32'h500;
    step();
    step();
    check("rst_mreq_pre", {31'd0, Mem_Req}, 1);
    Reset = 1'b1;
    step();
    check_reset_outputs("rst_abort");
    Reset = 1'b0; Data_Req = 1'b0;
    step();
    check("rst_no_ddone", {31'd0, Data_Done}, 0);
    check("rst_mreq_idle", {31'd0, Mem_Req}, 0);

    // after reset last grant is fetch, so data wins a tie
    Fetch_Req = 1'b1; Fetch_Addr = 32'h300;
    Data_Req = 1'b1; Data_Write = 1'b0; Data_Addr = 32'h400;
    step();
    check("pr_maddr_c1", Mem_Addr, 32'h400);
    Mem_Ready = 1'b1; Mem_RData = 32'h5;
    step();
    check("pr_ddone", {31'd0, Data_Done}, 1);
    Data_Req = 1'b0; Mem_Ready = 1'b0;
    step();
    check("pr_maddr_c3", Mem_Addr, 32'h300);
    Mem_Ready = 1'b1; Mem_RData = 32'h6;
    step();
    check("pr_fdone", {31'd0, Fetch_Done}, 1);
    Fetch_Req = 1'b0; Mem_Ready = 1'b0;
    step();

    // randomized rounds against a transaction-level model
    last_was_data = 1'b0;
    for (int r = 0; r < 40; r++) begin
      want_f = 1'($urandom_range(0, 1));
      want_d = 1'($urandom_range(0, 1));
      if (!want_f && !want_d) want_f = 1'b1;
      fa = $urandom; da = $urandom; dwd = $urandom;
      dw = 1'($urandom_range(0, 1));
      first_is_data = want_d && !(want_f && last_was_data);
      pend_f = want_f; pend_d = want_d;
      served_f = 0; served_d = 0;
      exp_f = 32'hx; exp_d = 32'hx;
      seen_req = 0; wait_cnt = 0;
      delay = $urandom_range(0, 3);
      Fetch_Req = want_f; Fetch_Addr = fa;
      Data_Req = want_d; Data_Addr = da;
      Data_Write = dw; Data_WData = dwd;
      for (int c = 0; c < 40 && (pend_f || pend_d); c++) begin
        step();
        check("rnd_stall", {31'd0, Stall},
              {31'd0, (pend_f & ~Fetch_Done) |
                      (pend_d & ~Data_Done)});
        if (Fetch_Done) begin
          check("rnd_f_served", {31'd0, served_f}, 1);
          check("rnd_fdata", Fetch_Data, exp_f);
          pend_f = 0; Fetch_Req = 0; last_was_data = 0;
        end
        if (Data_Done) begin
          check("rnd_d_served", {31'd0, served_d}, 1);
          check("rnd_ddata", Data_RData, exp_d);
          pend_d = 0; Data_Req = 0; last_was_data = 1;
        end
        cur_is_data = (pend_f && pend_d) ? first_is_data
                                         : pend_d;
        Mem_RData = $urandom;
        if (Mem_Req) begin
          if (!seen_req) begin
            seen_req = 1; wait_cnt = 0;
          end
          if (cur_is_data) begin
            check("rnd_d_maddr", Mem_Addr, da);
            check("rnd_d_mwr", {31'd0, Mem_Write}, {31'd0, dw});
            check("rnd_d_mwdata", Mem_WData, dwd);
          end else begin
            check("rnd_f_maddr", Mem_Addr, fa);
            check("rnd_f_mwr", {31'd0, Mem_Write}, 0);
          end
          if (wait_cnt == delay) begin
            rd = $urandom;
            Mem_RData = rd;
            Mem_Ready = 1'b1;
            if (cur_is_data) begin
              served_d = 1; exp_d = dw ? 32'd0 : rd;
            end else begin
              served_f = 1; exp_f = rd;
            end
          end else begin
            Mem_Ready = 1'b0;
          end
          wait_cnt++;
        end else begin
          seen_req = 0;
          delay = $urandom_range(0, 3);
          Mem_Ready = 1'($urandom_range(0, 1));
        end
      end
      check("rnd_round_done", {30'd0, pend_f, pend_d}, 0);
      Fetch_Req = 0; Data_Req = 0; Mem_Ready = 0;
      step();
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // watchdog ends a stuck fetch after 15 wait cycles
    begin
      int done_at;
      done_at = -1;
      check("to_err_pre", {31'd0, Timeout_Error}, 0);
      Mem_Ready = 1'b0;
      Fetch_Req = 1'b1; Fetch_Addr = 32'h44;
      for (int c = 1; c <= 40 && done_at < 0; c++) begin
        step();
        if (Fetch_Done) done_at = c;
      end
      check("to_done_cycle", done_at, 16);
      check("to_fdata", Fetch_Data, 0);
      check("to_err_set", {31'd0, Timeout_Error}, 1);
      Fetch_Req = 1'b0;
      for (int c = 0; c < 3; c++) begin
        step();
        check("to_err_sticky", {31'd0, Timeout_Error}, 1);
      end
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("to_err_clr", {31'd0, Timeout_Error}, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of both requesters and memory port.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 Parameter TIMEOUT_CYCLES, 15, wait-cycle limit; used only with MEM_ARB_TIMEOUT_EN.
REQ-004 Clock  in  1  single clock; all state updates on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Fetch_Req  in  1  instruction fetch request; held until Fetch_Done.
REQ-007 Fetch_Addr  in  ADDR_W  fetch address; stable while Fetch_Req is high.
REQ-008 Fetch_Done  out  1  one-cycle completion pulse for fetch.
REQ-009 Fetch_Data  out  DATA_W  fetched instruction; valid only while Fetch_Done is high.
REQ-010 Data_Req  in  1  memory-stage load/store request; held until Data_Done.
REQ-011 Data_Write  in  1  1 = store, 0 = load.
REQ-012 Data_Addr  in  ADDR_W  load/store address.
REQ-013 Data_WData  in  DATA_W  store data.
REQ-014 Data_Done  out  1  one-cycle completion pulse for data access.
REQ-015 Data_RData  out  DATA_W  load result; valid only while Data_Done is high.
REQ-016 Mem_Req, Mem_Write  out  1 each  registered memory strobe and direction.
REQ-017 Mem_Addr, Mem_WData  out  ADDR_W, DATA_W  registered, muxed from granted requester.
REQ-018 Mem_RData  in  DATA_W  memory read data, sampled with Mem_Ready.
REQ-019 Mem_Ready  in  1  memory completion; meaningful only while Mem_Req is high.
REQ-020 Stall  out  1  high whenever any request is pending and not yet completed; freezes stage sequencing.

Function
REQ-021 The FSM SHALL have states IDLE, FETCH_WAIT, DATA_WAIT.
REQ-022 In IDLE with any eligible request, the arbiter SHALL latch the winner's fields into Mem_* at the edge and enter the matching WAIT state; Mem_Req high from the next cycle.
REQ-023 Arbitration SHALL favour Data; exception: if the last completed grant was Data and Fetch_Req is high, Fetch wins.
REQ-024 A requester whose Done is high in the current cycle SHALL be ineligible in that cycle.
REQ-025 In a WAIT state, Mem_Ready sampled high SHALL, at that edge, pulse the matching Done, register Mem_RData into the matching data output, drop Mem_Req, and return to IDLE.
REQ-026 Minimum latency SHALL be Req (cycle 0) -> Mem_Req (cycle 1) -> Done (cycle 2) when Mem_Ready is high in cycle 1.
REQ-027 Mem_Ready while IDLE SHALL be ignored; Mem_* fields SHALL remain constant throughout a WAIT state.
REQ-028 Store completion SHALL leave Data_RData at 0.
REQ-029 Stall = (Fetch_Req & ~Fetch_Done) | (Data_Req & ~Data_Done), combinational.

Reset
REQ-030 Reset SHALL force IDLE, Mem_Req = 0, Mem_Write = 0, Mem_Addr = 0, Mem_WData = 0, both Done = 0, both data outputs = 0, last-grant = Fetch.
REQ-031 Reset during a WAIT state SHALL abort the access without any Done pulse; Mem_Req low in the cycle after Reset is sampled.

Configuration
REQ-032 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; at TIMEOUT_CYCLES without Mem_Ready the access SHALL end with Done pulsed, data output 0, and a sticky output Timeout_Error (1 bit, cleared only by Reset).
REQ-033 Without MEM_ARB_TIMEOUT_EN, WAIT states SHALL persist indefinitely and the Timeout_Error port SHALL not exist.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum, grant encoding (GRANT_FETCH, GRANT_DATA), and default widths.
REQ-035 The timeout counter SHALL be a sub-module mem_arb_watchdog (enable, clear, expired).

Verification
REQ-036 Fetch_Req only, Fetch_Addr=0x40, Mem_Ready high in cycle 1, Mem_RData=0x12345678 -> Fetch_Done and Fetch_Data=0x12345678 in cycle 2.
REQ-037 Fetch_Req and Data_Req rise together -> Data granted first; Fetch granted in the Data_Done cycle; Stall high until Fetch_Done.
REQ-038 Store Data_Addr=0x100, Data_WData=0xDEADBEEF, Mem_Ready delayed 3 cycles -> Mem_* stable 4 cycles, Data_Done once, Data_RData=0.
REQ-039 Reset asserted in cycle 2 of DATA_WAIT -> no Data_Done, Mem_Req low next cycle, all outputs at reset values.
REQ-040 With MEM_ARB_TIMEOUT_EN, Mem_Ready held low -> Done after 15 wait cycles, Timeout_Error stays 1 until Reset.
